// File: rtl/pixel_stream_packer.sv
// Regroups 0..IN_PIX pixels per cycle into output groups of exactly ppc_cfg pixels through a
// DEPTH-slot pixel FIFO; a line end flushes any partial group with a reduced strobe.
module pixel_stream_packer #(
    parameter int PIX_W   = 24,
    parameter int IN_PIX  = 4,
    parameter int MAX_PPC = 4,
    parameter int DEPTH   = 16
) (
    input  logic                       pixel_clk_i,
    input  logic                       reset_i,
    input  logic [2:0]                 pixel_per_clk_i,
    input  logic [IN_PIX*PIX_W-1:0]    in_data_i,
    input  logic [IN_PIX-1:0]          in_valid_i,
    input  logic                       in_line_end_i,
    output logic                       in_ready_o,
    output logic [MAX_PPC*PIX_W-1:0]   out_data_o,
    output logic [MAX_PPC-1:0]         out_strobe_o,
    output logic                       out_valid_o,
    output logic                       out_line_end_o,
    input  logic                       pixel_stream_stall_i,
    output logic [$clog2(DEPTH):0]     fill_level_o,
    output logic                       ovf_err_o,
    output logic                       proto_err_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PIX_W-1:0]           r_mem [DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic [CNT_W-1:0]           r_ppc_cfg;
    logic                       r_flush_pending;
    logic [MAX_PPC*PIX_W-1:0]   r_out_data;
    logic [MAX_PPC-1:0]         r_out_strobe;
    logic                       r_out_valid;
    logic                       r_out_line_end;
    logic                       r_ovf_err;
    logic                       r_proto_err;

    logic [CNT_W-1:0]           w_ppc_req;
    logic [CNT_W-1:0]           w_n;
    logic [CNT_W-1:0]           w_n_push;
    logic [IN_PIX-1:0]          w_run_mask;
    logic                       w_noncontig;
    logic                       w_ready;
    logic                       w_push;
    logic                       w_load;
    logic [CNT_W-1:0]           w_pop;
    logic                       w_line_end_pop;
    logic [PTR_W-1:0]           w_wr_idx [IN_PIX];
    logic [PTR_W-1:0]           w_rd_idx [MAX_PPC];
    logic [MAX_PPC*PIX_W-1:0]   w_grp_data;
    logic [MAX_PPC-1:0]         w_grp_strobe;

    // Unsupported or out-of-range PPC requests fall back to one pixel per group.
    always_comb begin
        w_ppc_req = CNT_W'(1);
        if (pixel_per_clk_i == 3'd2 && MAX_PPC >= 2)
            w_ppc_req = CNT_W'(2);
        else if (pixel_per_clk_i == 3'd4 && MAX_PPC >= 4)
            w_ppc_req = CNT_W'(4);
    end

    // Accepted lane count is the contiguous run of valid lanes starting at lane 0.
    always_comb begin
        logic run;
        w_n = '0;
        run = 1'b1;
        for (int k = 0; k < IN_PIX; k++) begin
            if (run && in_valid_i[k])
                w_n = CNT_W'(k + 1);
            else
                run = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < IN_PIX; gi++) begin : g_in_lane
            assign w_run_mask[gi] = (CNT_W'(gi) < w_n);
            assign w_wr_idx[gi]   = r_wr_ptr + PTR_W'(gi);
        end
    endgenerate

    assign w_noncontig = |(in_valid_i & ~w_run_mask);
    assign w_ready     = !reset_i && (r_count <= CNT_W'(DEPTH - IN_PIX));
    assign w_push      = w_ready && (w_n != '0);
    assign w_n_push    = w_push ? w_n : '0;

    // Pop decision uses only the registered count, so freshly pushed pixels wait one cycle.
    assign w_load = !r_out_valid || !pixel_stream_stall_i;

    always_comb begin
        w_pop = '0;
        if (w_load) begin
            if (r_count >= r_ppc_cfg)
                w_pop = r_ppc_cfg;
            else if (r_flush_pending && r_count != '0)
                w_pop = r_count;
        end
    end

    assign w_line_end_pop = r_flush_pending && (w_pop != '0) && (r_count == w_pop);

    generate
        for (genvar gi = 0; gi < MAX_PPC; gi++) begin : g_out_lane
            assign w_rd_idx[gi]     = r_rd_ptr + PTR_W'(gi);
            assign w_grp_strobe[gi] = (CNT_W'(gi) < w_pop);
            assign w_grp_data[gi*PIX_W +: PIX_W] =
                w_grp_strobe[gi] ? r_mem[w_rd_idx[gi]] : '0;
        end
    endgenerate

    always_ff @(posedge pixel_clk_i) begin
        for (int k = 0; k < IN_PIX; k++) begin
            if (w_push && (CNT_W'(k) < w_n))
                r_mem[w_wr_idx[k]] <= in_data_i[k*PIX_W +: PIX_W];
        end
    end

    always_ff @(posedge pixel_clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_ppc_cfg       <= CNT_W'(1);
            r_flush_pending <= 1'b0;
            r_out_data      <= '0;
            r_out_strobe    <= '0;
            r_out_valid     <= 1'b0;
            r_out_line_end  <= 1'b0;
            r_ovf_err       <= 1'b0;
            r_proto_err     <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
            r_count  <= r_count + w_n_push - w_pop;

            // Group size may only change between lines, when nothing is buffered.
            if (r_count == '0 && !r_flush_pending)
                r_ppc_cfg <= w_ppc_req;

            if (w_push && in_line_end_i)
                r_flush_pending <= 1'b1;
            else if (w_line_end_pop)
                r_flush_pending <= 1'b0;

            if (w_load) begin
                r_out_valid    <= (w_pop != '0);
                r_out_data     <= w_grp_data;
                r_out_strobe   <= w_grp_strobe;
                r_out_line_end <= w_line_end_pop;
            end

            if ((|in_valid_i) && !w_ready)
                r_ovf_err <= 1'b1;
            if (w_noncontig || (in_line_end_i && !w_push))
                r_proto_err <= 1'b1;
        end
    end

    assign in_ready_o     = w_ready;
    assign out_data_o     = r_out_data;
    assign out_strobe_o   = r_out_strobe;
    assign out_valid_o    = r_out_valid;
    assign out_line_end_o = r_out_line_end;
    assign fill_level_o   = r_count;
    assign ovf_err_o      = r_ovf_err;
    assign proto_err_o    = r_proto_err;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer: grouping, line-end flush, stall/backpressure,
// error flags and mid-line reset, all at default parameters.
module tb_pixel_stream_packer;
    localparam int PIX_W   = 24;
    localparam int IN_PIX  = 4;
    localparam int MAX_PPC = 4;
    localparam int DEPTH   = 16;

    logic                     clk = 1'b0;
    logic                     reset_i;
    logic [2:0]               ppc;
    logic [IN_PIX*PIX_W-1:0]  in_data;
    logic [IN_PIX-1:0]        in_valid;
    logic                     in_le;
    logic                     in_ready;
    logic [MAX_PPC*PIX_W-1:0] out_data;
    logic [MAX_PPC-1:0]       out_strobe;
    logic                     out_valid;
    logic                     out_le;
    logic                     stall;
    logic [4:0]               fill;
    logic                     ovf_err;
    logic                     proto_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pixel_stream_packer #(
        .PIX_W(PIX_W), .IN_PIX(IN_PIX), .MAX_PPC(MAX_PPC), .DEPTH(DEPTH)
    ) dut (
        .pixel_clk_i          (clk),
        .reset_i              (reset_i),
        .pixel_per_clk_i      (ppc),
        .in_data_i            (in_data),
        .in_valid_i           (in_valid),
        .in_line_end_i        (in_le),
        .in_ready_o           (in_ready),
        .out_data_o           (out_data),
        .out_strobe_o         (out_strobe),
        .out_valid_o          (out_valid),
        .out_line_end_o       (out_le),
        .pixel_stream_stall_i (stall),
        .fill_level_o         (fill),
        .ovf_err_o            (ovf_err),
        .proto_err_o          (proto_err)
    );

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [3:0] v, input logic le, input logic [95:0] d);
        in_valid = v;
        in_le    = le;
        in_data  = d;
    endtask

    task automatic idle();
        beat(4'b0000, 1'b0, 96'd0);
    endtask

    function automatic logic [95:0] grp(input logic [23:0] p0, input logic [23:0] p1,
                                        input logic [23:0] p2, input logic [23:0] p3);
        return {p3, p2, p1, p0};
    endfunction

    function automatic logic [23:0] spx(input int i);
        return 24'h5A0000 + 24'(i);
    endfunction

    function automatic logic [95:0] sgrp(input int i);
        return grp(spx(i), spx(i + 1), spx(i + 2), spx(i + 3));
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int next;
        reset_i = 1'b1;
        ppc     = 3'd4;
        stall   = 1'b0;
        idle();

        // Reset state
        tick();
        check("rst_ready", in_ready, 0);
        check("rst_valid", out_valid, 0);
        check("rst_fill", fill, 0);
        check("rst_errs", {ovf_err, proto_err}, 0);
        check("rst_data", out_data, 0);
        tick();
        reset_i = 1'b0;
        #1;
        check("ready_after_rst", in_ready, 1);

        // Test 1: ppc=4, two full beats
        beat(4'hF, 1'b0, grp(24'hA00000, 24'hA00001, 24'hA00002, 24'hA00003));
        tick();
        check("t1_fill_a", fill, 4);
        check("t1_lat_novalid", out_valid, 0);
        beat(4'hF, 1'b0, grp(24'hB00000, 24'hB00001, 24'hB00002, 24'hB00003));
        tick();
        idle();
        check("t1_valid_a", out_valid, 1);
        check("t1_data_a", out_data, grp(24'hA00000, 24'hA00001, 24'hA00002, 24'hA00003));
        check("t1_strobe_a", out_strobe, 4'hF);
        check("t1_le_a", out_le, 0);
        tick();
        check("t1_data_b", out_data, grp(24'hB00000, 24'hB00001, 24'hB00002, 24'hB00003));
        check("t1_fill_b", fill, 0);
        tick();
        check("t1_empty", out_valid, 0);

        // Test 2: ppc=2, 2 then 1 pixels with line end
        ppc = 3'd2;
        tick();
        beat(4'b0011, 1'b0, grp(24'hC00000, 24'hC00001, 24'd0, 24'd0));
        tick();
        beat(4'b0001, 1'b1, grp(24'hD00000, 24'd0, 24'd0, 24'd0));
        tick();
        idle();
        check("t2_strobe_c", out_strobe, 4'b0011);
        check("t2_data_c", out_data, grp(24'hC00000, 24'hC00001, 24'd0, 24'd0));
        check("t2_le_c", out_le, 0);
        tick();
        check("t2_strobe_d", out_strobe, 4'b0001);
        check("t2_data_d", out_data, grp(24'hD00000, 24'd0, 24'd0, 24'd0));
        check("t2_le_d", out_le, 1);
        check("t2_fill", fill, 0);
        tick();
        check("t2_idle", {out_valid, out_le}, 0);

        // Test 3: stall while streaming 4 pixels per beat
        ppc   = 3'd4;
        stall = 1'b1;
        tick();
        next = 0;
        for (int c = 0; c < 10; c++) begin
            if (in_ready && next < 20) begin
                beat(4'hF, 1'b0, sgrp(next));
                next += 4;
            end else begin
                idle();
            end
            tick();
            if (c >= 1) check($sformatf("t3_hold_%0d", c), {out_valid, out_strobe, out_data},
                              {1'b1, 4'hF, sgrp(0)});
        end
        idle();
        check("t3_fill_full", fill, 16);
        check("t3_ready_low", in_ready, 0);
        check("t3_no_ovf", ovf_err, 0);

        // Test 4: beat while not ready
        beat(4'hF, 1'b0, grp(24'hEEEEE0, 24'hEEEEE1, 24'hEEEEE2, 24'hEEEEE3));
        tick();
        idle();
        check("t4_ovf", ovf_err, 1);
        check("t4_fill", fill, 16);
        check("t4_hold", out_data, sgrp(0));
        stall = 1'b0;
        for (int g = 1; g < 5; g++) begin
            tick();
            check($sformatf("t4_drain_%0d", g), {out_valid, out_strobe, out_data},
                  {1'b1, 4'hF, sgrp(4 * g)});
        end
        tick();
        check("t4_drained", {out_valid, fill}, 0);
        check("t4_no_proto", proto_err, 0);

        // Test 5: non-contiguous valid
        beat(4'b0101, 1'b0, grp(24'hF00000, 24'hF00001, 24'hF00002, 24'hF00003));
        tick();
        check("t5_proto", proto_err, 1);
        check("t5_fill", fill, 1);
        beat(4'b0001, 1'b1, grp(24'hF10000, 24'd0, 24'd0, 24'd0));
        tick();
        idle();
        check("t5_fill2", fill, 2);
        tick();
        check("t5_flush", {out_valid, out_le, out_strobe, out_data},
              {1'b1, 1'b1, 4'b0011, grp(24'hF00000, 24'hF10000, 24'd0, 24'd0)});

        // Test 6: reset mid-line, then ppc=1
        tick();
        beat(4'b0011, 1'b0, grp(24'h700000, 24'h700001, 24'd0, 24'd0));
        tick();
        idle();
        check("t6_fill_pre", fill, 2);
        reset_i = 1'b1;
        #1;
        check("t6_rst_fill", fill, 0);
        check("t6_rst_ready", in_ready, 0);
        check("t6_rst_out", {out_valid, out_le, out_strobe, out_data}, 0);
        check("t6_rst_errs", {ovf_err, proto_err}, 0);
        ppc = 3'd1;
        tick();
        reset_i = 1'b0;
        beat(4'hF, 1'b0, grp(24'h800000, 24'h800001, 24'h800002, 24'h800003));
        tick();
        idle();
        check("t6_fill", fill, 4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t6_px_%0d", k), {out_valid, out_strobe, out_data},
                  {1'b1, 4'b0001, grp(24'h800000 + 24'(k), 24'd0, 24'd0, 24'd0)});
        end
        tick();
        check("t6_done", {out_valid, fill}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
